// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared types and constants for the EX->MEM skid stage (package ex_mem_pkg).
package ex_mem_pkg;

  localparam int unsigned CTRL_W     = 3;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_t;

  // Control sits in the MSBs so the skid buffer can clear it by position on flush.
  typedef struct packed {
    ctrl_t                  ctrl;
    logic [DEF_DATA_W-1:0]  result;
    logic [DEF_DATA_W-1:0]  store_data;
    logic [DEF_REG_AW-1:0]  dst;
  } payload_t;

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// EX-side and MEM-side handshake/bus signals of the EX->MEM stage.
interface ex_mem_skid_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              FlushE;
  logic              ValidE;
  logic              ReadyE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic [DATA_W-1:0] ALUResultIn;
  logic [DATA_W-1:0] ExMidIn;
  logic [REG_AW-1:0] ExDstIn;
  logic              ValidM;
  logic              ReadyM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALUResultOut;
  logic [DATA_W-1:0] ExMidOut;
  logic [REG_AW-1:0] ExDstOut;

  modport master (
    output FlushE, ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUResultIn, ExMidIn, ExDstIn, ReadyM,
    input  ReadyE, ValidM, RegWriteM, MemtoRegM, MemWriteM, ALUResultOut, ExMidOut, ExDstOut
  );

  modport slave (
    input  FlushE, ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUResultIn, ExMidIn, ExDstIn, ReadyM,
    output ReadyE, ValidM, RegWriteM, MemtoRegM, MemWriteM, ALUResultOut, ExMidOut, ExDstOut
  );
endinterface

// File: rtl/ex_mem_skid_stage_pipe_skid_buf.sv
// Generic main + one-entry skid register with registered ready and synchronous flush.
module pipe_skid_buf #(
  parameter int unsigned PAY_W            = 8,
  parameter int unsigned CTRL_W           = 0,
  parameter bit          FLUSH_KEEPS_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  // Bits that survive a flush: everything below the CTRL_W control MSBs, or nothing.
  localparam logic [PAY_W-1:0] KEEP_MASK =
    FLUSH_KEEPS_DATA ? ({PAY_W{1'b1}} >> CTRL_W) : '0;

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] main_data_q,  main_data_d;
  logic [PAY_W-1:0] skid_data_q,  skid_data_d;
  logic             accept, drain;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = main_data_q & KEEP_MASK;
      skid_data_d  = skid_data_q & KEEP_MASK;
    end else if (!main_valid_q || drain) begin
      // Main is free this edge: a held skid entry takes priority to keep order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(skid_valid_q && !main_valid_q));
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM valid/ready pipeline stage with skid buffer and flush.
// Optional stall counter output StallCnt enabled by macro EX_MEM_STALL_CNT_EN.
module ex_mem_skid_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W           = DEF_DATA_W,
  parameter int unsigned REG_AW           = DEF_REG_AW,
  parameter bit          FLUSH_KEEPS_DATA = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0]         StallCnt,
`endif
  ex_mem_skid_stage_if.slave  bus
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dst;
  } stage_pay_t;

  localparam int unsigned PAY_W = $bits(stage_pay_t);

  stage_pay_t pay_in, pay_out;
  logic       valid_m;

  always_comb begin
    pay_in                 = '0;
    pay_in.ctrl.reg_write  = bus.RegWriteE;
    pay_in.ctrl.mem_to_reg = bus.MemtoRegE;
    pay_in.ctrl.mem_write  = bus.MemWriteE;
    pay_in.result          = bus.ALUResultIn;
    pay_in.store_data      = bus.ExMidIn;
    pay_in.dst             = bus.ExDstIn;
  end

  pipe_skid_buf #(
    .PAY_W            (PAY_W),
    .CTRL_W           (CTRL_W),
    .FLUSH_KEEPS_DATA (FLUSH_KEEPS_DATA)
  ) u_buf (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .flush     (bus.FlushE),
    .in_valid  (bus.ValidE),
    .in_ready  (bus.ReadyE),
    .in_data   (pay_in),
    .out_valid (valid_m),
    .out_ready (bus.ReadyM),
    .out_data  (pay_out)
  );

  assign bus.ValidM       = valid_m;
  assign bus.RegWriteM    = pay_out.ctrl.reg_write  && valid_m;
  assign bus.MemtoRegM    = pay_out.ctrl.mem_to_reg && valid_m;
  assign bus.MemWriteM    = pay_out.ctrl.mem_write  && valid_m;
  assign bus.ALUResultOut = pay_out.result;
  assign bus.ExMidOut     = pay_out.store_data;
  assign bus.ExDstOut     = pay_out.dst;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_m && !bus.ReadyM && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed self-checking bench for ex_mem_skid_stage.
module tb_ex_mem_skid_stage;

  logic Clk;
  logic Rst_n;
  int   total;
  int   bad;

  ex_mem_skid_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] StallCnt;
`endif

  ex_mem_skid_stage #(.DATA_W(32), .REG_AW(5), .FLUSH_KEEPS_DATA(1'b1)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
`ifdef EX_MEM_STALL_CNT_EN
    .StallCnt (StallCnt),
`endif
    .bus      (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic v, input logic [31:0] res, input logic [31:0] mid,
                         input logic [4:0] dst, input logic rw, input logic mr, input logic mw);
    bus.ValidE      = v;
    bus.ALUResultIn = res;
    bus.ExMidIn     = mid;
    bus.ExDstIn     = dst;
    bus.RegWriteE   = rw;
    bus.MemtoRegE   = mr;
    bus.MemWriteE   = mw;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.FlushE = 1'b0;
    bus.ReadyM = 1'b1;
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with a valid entry presented
    Rst_n = 1'b0;
    present(1'b1, 32'h1234, 32'h55, 5'd3, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_validm", bus.ValidM, 1'b0);
    chk("rst_alu",    bus.ALUResultOut, 32'h0);
    chk("rst_readye", bus.ReadyE, 1'b1);
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    tick();
    chk("rel_validm", bus.ValidM, 1'b0);
    chk("rel_outs", {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.ExMidOut, bus.ExDstOut},
        {3'b000, 32'h0, 5'd0});
    chk("rel_readye", bus.ReadyE, 1'b1);
`ifdef EX_MEM_STALL_CNT_EN
    chk("rst_stallcnt", StallCnt, 32'd0);
`endif

    // Streaming A/B/C
    present(1'b1, 32'h10, 32'hA0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("strm_a", {bus.ValidM, bus.RegWriteM, bus.ALUResultOut, bus.ExMidOut, bus.ExDstOut},
        {2'b11, 32'h10, 32'hA0, 5'd1});
    present(1'b1, 32'h20, 32'hB0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("strm_b", {bus.ValidM, bus.RegWriteM, bus.ALUResultOut, bus.ExMidOut, bus.ExDstOut},
        {2'b11, 32'h20, 32'hB0, 5'd2});
    present(1'b1, 32'h30, 32'hC0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("strm_c", {bus.ValidM, bus.RegWriteM, bus.ALUResultOut, bus.ExMidOut, bus.ExDstOut},
        {2'b11, 32'h30, 32'hC0, 5'd3});
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("strm_drain", {bus.ValidM, bus.RegWriteM, bus.ReadyE}, 3'b001);
    chk("strm_hold_data", bus.ALUResultOut, 32'h30);

    // Back-pressure: A in main, B lands in skid while ReadyM=0
    present(1'b1, 32'h40, 32'h4, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_a_main", {bus.ValidM, bus.ALUResultOut}, {1'b1, 32'h40});
    bus.ReadyM = 1'b0;
    present(1'b1, 32'h50, 32'h5, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bp_a_stable", {bus.ValidM, bus.ALUResultOut, bus.ExDstOut}, {1'b1, 32'h40, 5'd4});
    chk("bp_readye_lo", bus.ReadyE, 1'b0);
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_still_a", {bus.ValidM, bus.ALUResultOut, bus.ReadyE}, {1'b1, 32'h40, 1'b0});
    bus.ReadyM = 1'b1;
    tick();
    chk("bp_b_main", {bus.ValidM, bus.MemtoRegM, bus.ALUResultOut, bus.ExDstOut},
        {2'b11, 32'h50, 5'd5});
    chk("bp_readye_hi", bus.ReadyE, 1'b1);
    tick();
    chk("bp_empty", bus.ValidM, 1'b0);

    // Flush under stall: main=A, skid=B, C presented with FlushE
    present(1'b1, 32'h60, 32'h6, 5'd6, 1'b1, 1'b0, 1'b1);
    tick();
    bus.ReadyM = 1'b0;
    present(1'b1, 32'h70, 32'h7, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    chk("fl_pre_readye", {bus.ValidM, bus.ALUResultOut, bus.ReadyE}, {1'b1, 32'h60, 1'b0});
    present(1'b1, 32'h80, 32'h8, 5'd8, 1'b1, 1'b0, 1'b1);
    bus.FlushE = 1'b1;
    tick();
    chk("fl_gated", {bus.ValidM, bus.RegWriteM, bus.MemWriteM, bus.ReadyE}, 4'b0001);
    chk("fl_keep_data", bus.ALUResultOut, 32'h60);
    bus.FlushE = 1'b0;
    bus.ReadyM = 1'b1;
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_no_c_no_b", {bus.ValidM, bus.ALUResultOut}, {1'b0, 32'h60});

    // Bubble gating: MemWriteE without ValidE never reaches MEM
    present(1'b0, 32'h90, 32'h9, 5'd9, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bub_memwrite", {bus.ValidM, bus.MemWriteM}, 2'b00);
    end
    present(1'b1, 32'h94, 32'h9, 5'd9, 1'b0, 1'b0, 1'b1);
    tick();
    chk("store_memwrite", {bus.ValidM, bus.MemWriteM, bus.RegWriteM, bus.ALUResultOut},
        {3'b110, 32'h94});
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();

`ifdef EX_MEM_STALL_CNT_EN
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    present(1'b1, 32'hA0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    chk("sc_zero", StallCnt, 32'd0);
    present(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ReadyM = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sc_five", StallCnt, 32'd5);
    bus.ReadyM = 1'b1;
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    chk("sc_flush_keeps", {bus.ValidM, StallCnt}, {1'b0, 32'd5});
    tick();
    chk("sc_after", StallCnt, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
